// File: rtl/inst_loader_if.sv
// Byte-stream handshake between an upstream byte source and the program loader.
// A byte moves on any cycle where byte_valid and byte_ready are both high.
interface inst_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/inst_loader.sv
// Boot-time program loader.
// Takes a framed byte stream: CNT_HI, CNT_LO, 4*N payload bytes, CHK.
// Payload bytes are packed big-endian into 32-bit words, and each finished word
// is written to instruction memory with a one-cycle load strobe.
// The CPU is held in reset until the whole image is in and the frame XORs to zero.
module inst_loader #(
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  inst_loader_if.slave       bus,
  output logic               load,
  output logic [31:0]        load_inst,
  output logic [31:0]        load_addr,
  output logic               cpu_rst,
  output logic               done,
  output logic               error,
  output logic [15:0]        words_loaded
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_CNT_HI, S_CNT_LO, S_PAYLOAD, S_CHK, S_DONE, S_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;          // word count N from the header
  logic [31:0] word_q, word_d;        // partially assembled instruction
  logic [1:0]  bcnt_q, bcnt_d;        // byte position inside the current word
  logic [7:0]  xor_q, xor_d;          // running XOR of every accepted byte
  logic        load_q, load_d;
  logic [31:0] load_inst_q, load_inst_d;
  logic [31:0] load_addr_q, load_addr_d;
  logic [15:0] words_q, words_d;

  logic        accept;
  logic        xfer;
  logic [15:0] n_full;
  logic [31:0] word_next;

  // Ready depends on state only (plus rst), so it stays high across load cycles.
  assign accept         = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                          (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign bus.byte_ready = !rst && accept;
  assign xfer           = bus.byte_valid && bus.byte_ready;
  assign n_full         = {cnt_q[15:8], bus.byte_data};
  assign word_next      = {word_q[23:0], bus.byte_data};

  // Next-state and datapath: one step per accepted byte; load is a single-cycle pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    bcnt_d      = bcnt_q;
    xor_d       = xor_q;
    load_d      = 1'b0;
    load_inst_d = load_inst_q;
    load_addr_d = load_addr_q;
    words_d     = words_q;
    if (xfer) begin
      xor_d = xor_q ^ bus.byte_data;
      case (state_q)
        S_CNT_HI: begin
          cnt_d[15:8] = bus.byte_data;
          state_d     = S_CNT_LO;
        end
        S_CNT_LO: begin
          cnt_d = n_full;
          if ({16'h0, n_full} > MAX_W) state_d = S_ERROR;
          else if (n_full == 16'h0)    state_d = S_CHK;
          else                         state_d = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          word_d = word_next;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // words_q still counts the words before this one, so it is this word's index.
            load_d      = 1'b1;
            load_inst_d = word_next;
            load_addr_d = BASE_ADDR + {14'h0, words_q, 2'b00};
            words_d     = words_q + 16'd1;
            if (words_q == cnt_q - 16'd1) state_d = S_CHK;
          end
        end
        S_CHK: begin
          state_d = ((xor_q ^ bus.byte_data) == 8'h00) ? S_DONE : S_ERROR;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers; rst discards any partially received frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CNT_HI;
      cnt_q       <= 16'h0;
      word_q      <= 32'h0;
      bcnt_q      <= 2'd0;
      xor_q       <= 8'h0;
      load_q      <= 1'b0;
      load_inst_q <= 32'h0;
      load_addr_q <= BASE_ADDR;
      words_q     <= 16'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      bcnt_q      <= bcnt_d;
      xor_q       <= xor_d;
      load_q      <= load_d;
      load_inst_q <= load_inst_d;
      load_addr_q <= load_addr_d;
      words_q     <= words_d;
    end
  end

  assign load         = load_q;
  assign load_inst    = load_inst_q;
  assign load_addr    = load_addr_q;
  assign words_loaded = words_q;
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign cpu_rst      = (state_q != S_DONE);

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: the stimulus side pushes each expected
// load (instruction, address, cycle) as the 4th byte of a word is accepted;
// a monitor pops and compares whenever load is seen.
module tb_inst_loader;
  localparam int          MAXW = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, cpu_rst, done, error;
  logic [31:0] load_inst, load_addr;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  inst_loader_if bus();

  inst_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .load(load), .load_inst(load_inst), .load_addr(load_addr),
    .cpu_rst(cpu_rst), .done(done), .error(error), .words_loaded(words_loaded)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cyc = 0;
  int          exp_words;
  logic [31:0] wbuf [0:7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every load strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && load === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_load: inst %h addr %h at cycle %0d", load_inst, load_addr, cyc);
      end else begin
        mon_e = q.pop_front();
        if (load_inst !== mon_e.inst || load_addr !== mon_e.addr || cyc !== mon_e.cyc) begin
          n_bad++;
          $display("FAIL load: got inst %h addr %h cyc %0d expected inst %h addr %h cyc %0d",
                   load_inst, load_addr, cyc, mon_e.inst, mon_e.addr, mon_e.cyc);
        end
      end
    end
  end

  // Offer one byte and wait for its handshake; returns at posedge+1 after transfer.
  task automatic send(input logic [7:0] b, input bit gaps, output int waits);
    logic r;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    waits = 0;
    forever begin
      @(negedge clk); r = bus.byte_ready;
      @(posedge clk); #1;
      if (r) break;
      waits++;
      if (waits > 20) begin
        n_cmp++; n_bad++;
        $display("FAIL handshake_timeout: byte %h never accepted", b);
        break;
      end
    end
  endtask

  // Send a frame of n words taken from wbuf; chk_flip corrupts the checksum byte.
  task automatic frame(input logic [15:0] n, input logic [7:0] chk_flip, input bit gaps,
                       output int total_waits);
    logic [7:0] x, b;
    int w;
    exp_t e;
    x = 8'h0; total_waits = 0;
    send(n[15:8], gaps, w); total_waits += w; x ^= n[15:8];
    send(n[7:0],  gaps, w); total_waits += w; x ^= n[7:0];
    if (n > 16'(MAXW)) begin
      bus.byte_valid = 1'b0;
      return;
    end
    for (int k = 0; k < int'(n); k++) begin
      for (int j = 0; j < 4; j++) begin
        b = wbuf[k][31-8*j -: 8];
        x ^= b;
        send(b, gaps, w); total_waits += w;
        if (j == 3) begin
          e.inst = wbuf[k];
          e.addr = BASE + 32'(4 * exp_words);
          e.cyc  = cyc;
          q.push_back(e);
          exp_words++;
        end
      end
    end
    // The checksum byte makes the XOR of the whole frame zero.
    send(x ^ chk_flip, gaps, w); total_waits += w;
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_reset(input bit check_state);
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    if (check_state) begin
      check("rst_ready", {31'h0, bus.byte_ready}, 32'h0);
      check("rst_load", {31'h0, load}, 32'h0);
      check("rst_load_inst", load_inst, 32'h0);
      check("rst_load_addr", load_addr, BASE);
      check("rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
      check("rst_done_error", {30'h0, done, error}, 32'h0);
      check("rst_words", {16'h0, words_loaded}, 32'h0);
    end
    q.delete();
    exp_words = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Sampled one cycle after the last handshake.
  task automatic check_end(input string tag, input bit exp_done, input bit exp_err,
                           input logic [15:0] exp_n);
    @(negedge clk);
    check({tag, "_done"}, {31'h0, done}, {31'h0, exp_done});
    check({tag, "_error"}, {31'h0, error}, {31'h0, exp_err});
    check({tag, "_cpu_rst"}, {31'h0, cpu_rst}, {31'h0, !exp_done});
    check({tag, "_words"}, {16'h0, words_loaded}, {16'h0, exp_n});
    check({tag, "_ready_low"}, {31'h0, bus.byte_ready}, 32'h0);
    check({tag, "_pending"}, 32'(q.size()), 32'h0);
  endtask

  initial begin
    int tw, w;
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(posedge clk);
    do_reset(1'b1);
    @(negedge clk);
    check("ready_after_rst", {31'h0, bus.byte_ready}, 32'h1);
    @(posedge clk); #1;

    // T1: one word 12345678
    wbuf[0] = 32'h1234_5678;
    frame(16'd1, 8'h00, 1'b0, tw);
    check_end("t1", 1'b1, 1'b0, 16'd1);
    check("t1_inst_hold", load_inst, 32'h1234_5678);
    check("t1_addr_hold", load_addr, BASE);

    // T2: two words at full rate, ready must never drop
    do_reset(1'b0);
    wbuf[0] = 32'hDEAD_BEEF; wbuf[1] = 32'h0102_0304;
    frame(16'd2, 8'h00, 1'b0, tw);
    check("t2_ready_no_drop", 32'(tw), 32'h0);
    check_end("t2", 1'b1, 1'b0, 16'd2);
    // Held valid after done must change nothing
    bus.byte_valid = 1'b1; bus.byte_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1 bus.byte_valid = 1'b0;
    check_end("t2_idle", 1'b1, 1'b0, 16'd2);

    // T3: empty image, good and bad checksum
    do_reset(1'b0);
    frame(16'd0, 8'h00, 1'b0, tw);
    check_end("t3_good", 1'b1, 1'b0, 16'd0);
    do_reset(1'b0);
    frame(16'd0, 8'h01, 1'b0, tw);
    check_end("t3_bad", 1'b0, 1'b1, 16'd0);

    // T4: count above MAX_WORDS, then a refused byte stream
    do_reset(1'b0);
    frame(16'd5, 8'h00, 1'b0, tw);
    check_end("t4", 1'b0, 1'b1, 16'd0);
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.byte_data = 8'(i * 37);
      @(posedge clk);
    end
    #1 bus.byte_valid = 1'b0;
    check_end("t4_idle", 1'b0, 1'b1, 16'd0);

    // Boundary: count exactly MAX_WORDS is accepted
    do_reset(1'b0);
    wbuf[0] = 32'hA0A1_A2A3; wbuf[1] = 32'hB0B1_B2B3;
    wbuf[2] = 32'hC0C1_C2C3; wbuf[3] = 32'hFFFF_0000;
    frame(16'd4, 8'h00, 1'b0, tw);
    check_end("max", 1'b1, 1'b0, 16'd4);
    check("max_last_addr", load_addr, BASE + 32'd12);

    // T5: T1 frame with a corrupted checksum
    do_reset(1'b0);
    wbuf[0] = 32'h1234_5678;
    frame(16'd1, 8'h55, 1'b0, tw);
    check_end("t5", 1'b0, 1'b1, 16'd1);

    // T6: reset after two payload bytes, then a clean T1 frame
    do_reset(1'b0);
    send(8'h00, 1'b0, w); send(8'h01, 1'b0, w);
    send(8'h12, 1'b0, w); send(8'h34, 1'b0, w);
    bus.byte_valid = 1'b0;
    do_reset(1'b0);
    frame(16'd1, 8'h00, 1'b0, tw);
    check_end("t6", 1'b1, 1'b0, 16'd1);
    do_reset(1'b0);
    frame(16'd1, 8'h00, 1'b1, tw);
    check_end("t6_gaps", 1'b1, 1'b0, 16'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
